battleship_board_engine: RTL

//  Game-state engine directly upstream of the VGA board renderer. Holds both players' 10x10 boards
//  (2 bits/cell) and accepts ship placement and shots. Resolves each shot to hit/miss, tracks turns and wins,
//  and drives the row buses A..J / OA..OJ and playerTurn that the renderer consumes every frame.

---
 rtl/battleship_board_engine_pkg.sv | 48 ++++
 rtl/battleship_board_engine_if.sv | 35 +++
 rtl/battleship_board_engine_board_bank.sv | 64 ++++++
 rtl/battleship_board_engine.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/battleship_board_engine_pkg.sv
// -----------------------------------------------------------------------------
// battleship_board_engine_pkg
// Shared definitions for the battleship board engine:
//   - board geometry (BOARD_DIM, ROW_W)
//   - cell codes (these match the renderer colours)
//   - shot result codes
//   - FSM state encoding
//   - fog_row(): hides unhit ships in an opponent row
// No ports (package).
// -----------------------------------------------------------------------------
package battleship_board_engine_pkg;

   localparam int BOARD_DIM = 10;
   localparam int ROW_W     = 2 * BOARD_DIM;

   localparam logic [1:0] CELL_WATER = 2'b00;
   localparam logic [1:0] CELL_SHIP  = 2'b01;
   localparam logic [1:0] CELL_MISS  = 2'b10;
   localparam logic [1:0] CELL_HIT   = 2'b11;

   localparam logic [1:0] RES_MISS    = 2'b00;
   localparam logic [1:0] RES_HIT     = 2'b01;
   localparam logic [1:0] RES_REPEAT  = 2'b10;
   localparam logic [1:0] RES_INVALID = 2'b11;

   typedef enum logic [2:0] {
      ST_SETUP    = 3'd0,
      ST_IDLE     = 3'd1,
      ST_CHECK    = 3'd2,
      ST_REPORT   = 3'd3,
      ST_GAMEOVER = 3'd4
   } state_e;

   // Replace every ship cell with water so the opponent cannot see unhit ships
   function automatic logic [ROW_W-1:0] fog_row(input logic [ROW_W-1:0] row);
      logic [ROW_W-1:0] masked;
      masked = row;
      for (int c = 0; c < BOARD_DIM; c++) begin
         if (row[2*c +: 2] == CELL_SHIP) begin
            masked[2*c +: 2] = CELL_WATER;
         end else begin
            masked[2*c +: 2] = row[2*c +: 2];
         end
      end
      return masked;
   endfunction

endpackage

// File: rtl/battleship_board_engine_if.sv
// -----------------------------------------------------------------------------
// battleship_board_engine_if
// Control/handshake bundle between the game controller (master) and the
// board engine (slave): new game, ship placement, start, the fire/result
// handshake, and the turn / game-over status.
// -----------------------------------------------------------------------------
interface battleship_board_engine_if;
   logic       new_game;
   logic       place_valid;
   logic       place_player;
   logic [3:0] place_row;
   logic [3:0] place_col;
   logic       start;
   logic       fire_valid;
   logic       fire_ready;
   logic [3:0] fire_row;
   logic [3:0] fire_col;
   logic       result_valid;
   logic [1:0] result;
   logic       playerTurn;
   logic       game_over;
   logic       winner;

   modport master (
      output new_game, place_valid, place_player, place_row, place_col, start,
             fire_valid, fire_row, fire_col,
      input  fire_ready, result_valid, result, playerTurn, game_over, winner
   );

   modport slave (
      input  new_game, place_valid, place_player, place_row, place_col, start,
             fire_valid, fire_row, fire_col,
      output fire_ready, result_valid, result, playerTurn, game_over, winner
   );
endinterface

// File: rtl/battleship_board_engine_board_bank.sv
// -----------------------------------------------------------------------------
// battleship_board_engine_board_bank
// One player's 10x10 board, 2 bits per cell, stored as 10 rows of 20 bits.
// Column 0 occupies bits [19:18] of a row, column 9 bits [1:0].
// Ports:
//   clock50, reset      clock, async active-high reset (board to all water)
//   clear               sync clear, wins over a write in the same cycle
//   wr_en/wr_row/wr_col/wr_code   single write port
//   rd_row/rd_col -> rd_code      single combinational read port
//   rows                all rows, for the renderer output mux
// Out-of-range coordinates match no cell: writes are dropped, reads give water.
// -----------------------------------------------------------------------------
module battleship_board_engine_board_bank
   import battleship_board_engine_pkg::*;
(
   input  logic                            clock50,
   input  logic                            reset,
   input  logic                            clear,
   input  logic                            wr_en,
   input  logic [3:0]                      wr_row,
   input  logic [3:0]                      wr_col,
   input  logic [1:0]                      wr_code,
   input  logic [3:0]                      rd_row,
   input  logic [3:0]                      rd_col,
   output logic [1:0]                      rd_code,
   output logic [BOARD_DIM-1:0][ROW_W-1:0] rows
);

   logic [BOARD_DIM-1:0][ROW_W-1:0] cells_r;

   // Cell storage with sync clear and a single write port
   always_ff @(posedge clock50 or posedge reset) begin
      if (reset) begin
         cells_r <= '0;
      end else if (clear) begin
         cells_r <= '0;
      end else if (wr_en) begin
         for (int r = 0; r < BOARD_DIM; r++) begin
            for (int c = 0; c < BOARD_DIM; c++) begin
               if (wr_row == 4'(r) && wr_col == 4'(c)) begin
                  cells_r[r][ROW_W-1-2*c -: 2] <= wr_code;
               end
            end
         end
      end
   end

   // Read port: decode row/col onto one cell
   always_comb begin
      rd_code = CELL_WATER;
      for (int r = 0; r < BOARD_DIM; r++) begin
         for (int c = 0; c < BOARD_DIM; c++) begin
            if (rd_row == 4'(r) && rd_col == 4'(c)) begin
               rd_code = cells_r[r][ROW_W-1-2*c -: 2];
            end else begin
               rd_code = rd_code;
            end
         end
      end
   end

   assign rows = cells_r;

endmodule

// File: rtl/battleship_board_engine.sv
// -----------------------------------------------------------------------------
// battleship_board_engine
// Game-state engine feeding the VGA board renderer. Holds both boards,
// accepts ship placement and shots, resolves hit/miss/repeat/invalid,
// tracks turns and the win, and drives the row buses every cycle.
// Ports:
//   clock50, reset   system clock, async active-high reset
//   ctl              control/handshake bundle (battleship_board_engine_if.slave)
//   A..J             current player's own board rows (registered)
//   OA..OJ           opponent board rows as the current player sees them (registered)
// Build option: FOG_OF_WAR_EN -- when defined, OA..OJ show unhit ships as water.
// Shot timeline: accept at N, CHECK at N+1 (board write), REPORT at N+2
// (result pulse, turn toggle), IDLE again at N+3.
// -----------------------------------------------------------------------------
module battleship_board_engine
   import battleship_board_engine_pkg::*;
#(
   parameter int SHIP_CELLS = 17
)(
   input  logic                     clock50,
   input  logic                     reset,
   battleship_board_engine_if.slave ctl,
   output logic [ROW_W-1:0] A, B, C, D, E, F, G, H, I, J,
   output logic [ROW_W-1:0] OA, OB, OC, OD, OE, OF, OG, OH, OI, OJ
);

   localparam logic [4:0] SHIP_LIMIT = 5'(SHIP_CELLS);

   state_e                          state_r;
   logic [3:0]                      shot_row_r, shot_col_r;
   logic [1:0][4:0]                 hits_r;
   logic                            win_r, turn_r, fire_ready_r, result_valid_r;
   logic                            game_over_r, winner_r;
   logic [1:0]                      result_r;
   logic [BOARD_DIM-1:0][ROW_W-1:0] own_r, opp_r;

   logic [1:0][BOARD_DIM-1:0][ROW_W-1:0] bank_rows_s;
   logic [1:0][1:0]                      bank_rd_s;
   logic [1:0]                           bank_we_s;
   logic [3:0]                           wr_row_s, wr_col_s;
   logic [1:0]                           wr_code_s, opp_code_s, shot_code_s;
   logic [4:0]                           hits_inc_s;

   for (genvar p = 0; p < 2; p++) begin : g_bank
      battleship_board_engine_board_bank u_board_bank (
         .clock50 (clock50),
         .reset   (reset),
         .clear   (ctl.new_game),
         .wr_en   (bank_we_s[p]),
         .wr_row  (wr_row_s),
         .wr_col  (wr_col_s),
         .wr_code (wr_code_s),
         .rd_row  (shot_row_r),
         .rd_col  (shot_col_r),
         .rd_code (bank_rd_s[p]),
         .rows    (bank_rows_s[p])
      );
   end

   // Shot resolution and board write steering (placement in SETUP, marking in CHECK)
   always_comb begin
      opp_code_s = turn_r ? bank_rd_s[0] : bank_rd_s[1];
      hits_inc_s = (hits_r[turn_r] < SHIP_LIMIT) ? hits_r[turn_r] + 5'd1 : hits_r[turn_r];
      wr_row_s   = ctl.place_row;
      wr_col_s   = ctl.place_col;
      wr_code_s  = CELL_SHIP;
      bank_we_s  = 2'b00;
      if (shot_row_r >= 4'(BOARD_DIM) || shot_col_r >= 4'(BOARD_DIM)) begin
         shot_code_s = RES_INVALID;
      end else if (opp_code_s == CELL_WATER) begin
         shot_code_s = RES_MISS;
      end else if (opp_code_s == CELL_SHIP) begin
         shot_code_s = RES_HIT;
      end else begin
         shot_code_s = RES_REPEAT;
      end
      if (state_r == ST_SETUP && ctl.place_valid &&
          ctl.place_row < 4'(BOARD_DIM) && ctl.place_col < 4'(BOARD_DIM)) begin
         bank_we_s[ctl.place_player] = 1'b1;
      end else if (state_r == ST_CHECK &&
                   (shot_code_s == RES_MISS || shot_code_s == RES_HIT)) begin
         wr_row_s  = shot_row_r;
         wr_col_s  = shot_col_r;
         wr_code_s = (shot_code_s == RES_HIT) ? CELL_HIT : CELL_MISS;
         bank_we_s[~turn_r] = 1'b1;
      end else begin
         bank_we_s = 2'b00;
      end
   end

   // Game FSM with registered handshake/status outputs; new_game overrides everything
   always_ff @(posedge clock50 or posedge reset) begin
      if (reset) begin
         state_r        <= ST_SETUP;
         shot_row_r     <= 4'd0;
         shot_col_r     <= 4'd0;
         hits_r         <= '0;
         win_r          <= 1'b0;
         turn_r         <= 1'b0;
         fire_ready_r   <= 1'b0;
         result_valid_r <= 1'b0;
         result_r       <= RES_MISS;
         game_over_r    <= 1'b0;
         winner_r       <= 1'b0;
      end else if (ctl.new_game) begin
         state_r        <= ST_SETUP;
         hits_r         <= '0;
         win_r          <= 1'b0;
         turn_r         <= 1'b0;
         fire_ready_r   <= 1'b0;
         result_valid_r <= 1'b0;
         result_r       <= RES_MISS;
         game_over_r    <= 1'b0;
         winner_r       <= 1'b0;
      end else begin
         result_valid_r <= 1'b0;
         case (state_r)
            ST_SETUP: begin
               if (ctl.start) begin
                  state_r      <= ST_IDLE;
                  turn_r       <= 1'b0;
                  fire_ready_r <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (ctl.fire_valid) begin
                  shot_row_r   <= ctl.fire_row;
                  shot_col_r   <= ctl.fire_col;
                  fire_ready_r <= 1'b0;
                  state_r      <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               // Result, counter and turn all become visible together in REPORT
               result_valid_r <= 1'b1;
               result_r       <= shot_code_s;
               state_r        <= ST_REPORT;
               win_r          <= 1'b0;
               if (shot_code_s == RES_HIT) begin
                  hits_r[turn_r] <= hits_inc_s;
                  if (hits_inc_s == SHIP_LIMIT) begin
                     win_r <= 1'b1;
                  end else begin
                     turn_r <= ~turn_r;
                  end
               end else if (shot_code_s == RES_MISS) begin
                  turn_r <= ~turn_r;
               end
            end
            ST_REPORT: begin
               if (win_r) begin
                  state_r     <= ST_GAMEOVER;
                  game_over_r <= 1'b1;
                  winner_r    <= turn_r;
               end else begin
                  state_r      <= ST_IDLE;
                  fire_ready_r <= 1'b1;
               end
            end
            ST_GAMEOVER: begin
               state_r <= ST_GAMEOVER;
            end
            default: begin
               state_r      <= ST_SETUP;
               fire_ready_r <= 1'b0;
            end
         endcase
      end
   end

   // Renderer row registers follow the board contents and the current turn
   always_ff @(posedge clock50 or posedge reset) begin
      if (reset) begin
         own_r <= '0;
         opp_r <= '0;
      end else begin
         for (int r = 0; r < BOARD_DIM; r++) begin
            own_r[r] <= bank_rows_s[turn_r][r];
`ifdef FOG_OF_WAR_EN
            opp_r[r] <= fog_row(bank_rows_s[~turn_r][r]);
`else
            opp_r[r] <= bank_rows_s[~turn_r][r];
`endif
         end
      end
   end

   assign ctl.fire_ready   = fire_ready_r;
   assign ctl.result_valid = result_valid_r;
   assign ctl.result       = result_r;
   assign ctl.playerTurn   = turn_r;
   assign ctl.game_over    = game_over_r;
   assign ctl.winner       = winner_r;

   assign {A, B, C, D, E, F, G, H, I, J} =
      {own_r[0], own_r[1], own_r[2], own_r[3], own_r[4],
       own_r[5], own_r[6], own_r[7], own_r[8], own_r[9]};
   assign {OA, OB, OC, OD, OE, OF, OG, OH, OI, OJ} =
      {opp_r[0], opp_r[1], opp_r[2], opp_r[3], opp_r[4],
       opp_r[5], opp_r[6], opp_r[7], opp_r[8], opp_r[9]};

endmodule
